sipo_ctrl: RTL and testbench

Sequencer for the LSTM input deserialiser. It drives the input-memory address and the shift-register shift enable so that one (NUM-1)-word input vector x_t is loaded per timestep. It then presents the full vector to the forward-propagation datapath with a valid/ready handshake, and repeats for NUM_ITERATIONS timesteps. It replaces the free-running address counter: the shift register only shifts when this block says so, and the consumer only sees a vector when it is complete.

---
 rtl/sipo_ctrl_if.sv | 25 ++
 rtl/sipo_ctrl.sv | 76 +++++++
 tb/tb_sipo_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_ctrl_if.sv
// Handshake bundle between the input-deserialiser sequencer and its environment
// (input memory, shift register, forward-propagation consumer).
interface sipo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic             o_ready;
  logic [WIDTH-1:0] addr;
  logic             shift_en;
  logic             o_valid;
  logic [WIDTH-1:0] step;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, o_ready,
    output addr, shift_en, o_valid, step, busy, done
  );

  modport slave (
    output start, abort, o_ready,
    input  addr, shift_en, o_valid, step, busy, done
  );
endinterface

// File: rtl/sipo_ctrl.sv
// Sequencer for the LSTM input deserialiser: loads one (NUM-1)-word vector per
// timestep into the external shift register and hands it off with valid/ready.
module sipo_ctrl #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 69,
  parameter int NUM_ITERATIONS = 8
) (
  input  logic         clk,
  input  logic         rst,
  sipo_ctrl_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               KW        = (NUM > 2) ? $clog2(NUM - 1) : 1;
  localparam logic [KW-1:0]    K_LAST    = KW'(NUM - 2);
  localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'(NUM_ITERATIONS - 1);

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] step_q;

  // addr_q is a running counter: it already equals step*(NUM-1)+k, so the
  // next timestep simply continues from last+1 without any multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      addr_q <= '0;
      step_q <= '0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_LOAD;
            k      <= '0;
            addr_q <= '0;
            step_q <= '0;
          end
        end
        S_LOAD: begin
          addr_q <= addr_q + WIDTH'(1);
          if (k == K_LAST) state <= S_WAIT;
          else             k     <= k + KW'(1);
        end
        S_WAIT: begin
          if (bus.o_ready) begin
            if (step_q == STEP_LAST) begin
              state <= S_DONE;
            end else begin
              state  <= S_LOAD;
              step_q <= step_q + WIDTH'(1);
              k      <= '0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr     = addr_q;
  assign bus.step     = step_q;
  assign bus.shift_en = (state == S_LOAD);
  assign bus.o_valid  = (state == S_WAIT);
  assign bus.busy     = (state == S_LOAD) || (state == S_WAIT);
  assign bus.done     = (state == S_DONE);

endmodule

// File: tb/tb_sipo_ctrl.sv
// Scoreboard bench for sipo_ctrl: driver pushes expected shifts/vectors/done
// times, a negedge monitor pops and compares whenever the DUT presents them.
module tb_sipo_ctrl;
  localparam int WIDTH = 32;
  localparam int NUM   = 5;
  localparam int NI    = 3;
  localparam int VW    = NUM - 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sipo_ctrl_if #(.WIDTH(WIDTH)) bus();

  sipo_ctrl #(.WIDTH(WIDTH), .NUM(NUM), .NUM_ITERATIONS(NI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment model: combinational memory feeding a VW-word shift register.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA500_0000 ^ (a * 32'd7 + 32'd3);
  endfunction

  logic [31:0] sr [VW];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VW; i++) sr[i] <= '0;
    end else if (bus.shift_en) begin
      for (int i = 0; i < VW - 1; i++) sr[i] <= sr[i+1];
      sr[VW-1] <= mem(bus.addr);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] step;
  } shift_t;

  shift_t      exp_shift [$];
  logic [31:0] exp_vstep [$];
  int          exp_done  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.shift_en === 1'b1) begin
        if (exp_shift.size() == 0) unexp("shift");
        else begin
          shift_t e;
          e = exp_shift.pop_front();
          chk("shift_addr", bus.addr, e.addr);
          chk("shift_step", bus.step, e.step);
        end
      end
      if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
        if (exp_vstep.size() == 0) unexp("vector");
        else begin
          logic [31:0] s;
          s = exp_vstep.pop_front();
          chk("vec_step", bus.step, s);
          for (int i = 0; i < VW; i++)
            chk("vec_word", sr[i], mem(s * VW + i));
        end
      end
      if (bus.done === 1'b1) begin
        if (exp_done.size() == 0) unexp("done");
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expectations for a sequence whose start edge is the next posedge.
  task automatic push_seq(input int shifts, input int vecs, input bit with_done, input int extra);
    int c0;
    c0 = cyc + 1;
    for (int a = 0; a < shifts; a++) begin
      shift_t e;
      e.addr = a;
      e.step = a / VW;
      exp_shift.push_back(e);
    end
    for (int s = 0; s < vecs; s++) exp_vstep.push_back(s);
    if (with_done) exp_done.push_back(c0 + NUM * NI + extra);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_shift.size() + exp_vstep.size() + exp_done.size()) != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, 32'(exp_shift.size() + exp_vstep.size() + exp_done.size()), 32'd0);
    tick(4);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_addr"},     bus.addr, 32'd0);
    chk({name, "_step"},     bus.step, 32'd0);
    chk({name, "_shift_en"}, 32'(bus.shift_en), 32'd0);
    chk({name, "_o_valid"},  32'(bus.o_valid), 32'd0);
    chk({name, "_busy"},     32'(bus.busy), 32'd0);
    chk({name, "_done"},     32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.o_ready = 1'b0;

    // Reset applies without a clock edge
    #3 rst = 1'b1;
    #1 chk_zero_outputs("rst_async");
    tick(3);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_shift_en", 32'(bus.shift_en), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      tick(1);
    end

    // Full sequence, o_ready held high
    bus.o_ready = 1'b1;
    push_seq(NI * VW, NI, 1'b1, 0);
    do_start();
    drain("full_drain");

    // Back-pressure: 6 low cycles at the step-1 vector
    push_seq(NI * VW, NI, 1'b1, 6);
    do_start();
    tick(9);
    bus.o_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("bp_o_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_shift_en", 32'(bus.shift_en), 32'd0);
      chk("bp_addr", bus.addr, 32'd8);
      tick(1);
    end
    bus.o_ready = 1'b1;
    @(negedge clk);
    chk("bp_o_valid_last", 32'(bus.o_valid), 32'd1);
    drain("bp_drain");

    // Abort during LOAD at step 1, k=2
    push_seq(VW + 3, 1, 1'b0, 0);
    do_start();
    tick(7);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_shift_en", 32'(bus.shift_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    tick(12);
    drain("abort_drain");
    push_seq(NI * VW, NI, 1'b1, 0);
    do_start();
    drain("restart_drain");

    // Start pulses while busy are ignored
    push_seq(NI * VW, NI, 1'b1, 0);
    do_start();
    tick(2);
    bus.start = 1'b1;
    tick(4);
    bus.start = 1'b0;
    tick(3);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    drain("ignore_drain");

    // start together with abort in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("sa_busy", 32'(bus.busy), 32'd0);
      chk("sa_shift_en", 32'(bus.shift_en), 32'd0);
      tick(1);
    end

    // Async reset in WAIT at step 2, then a clean sequence
    push_seq(NI * VW, NI - 1, 1'b0, 0);
    do_start();
    tick(13);
    bus.o_ready = 1'b0;
    tick(1);
    @(negedge clk);
    chk("wait2_o_valid", 32'(bus.o_valid), 32'd1);
    chk("wait2_step", bus.step, 32'd2);
    #1 rst = 1'b1;
    #1 chk_zero_outputs("rst_wait");
    chk("rst_sr", sr[0], 32'd0);
    tick(2);
    rst = 1'b0;
    drain("rst_wait_drain");
    bus.o_ready = 1'b1;
    push_seq(NI * VW, NI, 1'b1, 0);
    do_start();
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
